// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter on the core's data-memory bus.
//
// Stores to TX_DATA_ADDR push Write_Data_i[7:0] into a small FIFO. The FSM drains
// the FIFO and serializes each byte on Tx_o: one start bit, eight data bits LSB
// first, then one stop bit, each held for BAUD_DIV clocks. Frames run back to back
// while the FIFO has data. A store that finds the FIFO full is dropped and sets a
// sticky overflow flag. Writing bit 2 of STATUS_ADDR clears that flag.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous active-low reset
//   Mem_Write_i   store strobe
//   Mem_Read_i    load strobe
//   Address_i     byte address from the ALU
//   Write_Data_i  store data (rs2)
//   Read_Data_o   combinational STATUS readback; 0 for any other access
//                 [0] busy, [1] full, [2] overflow, [3] empty, [12:8] FIFO count
//   Tx_o          serial line, idle high
module uart_tx_mmio #(
  parameter int unsigned BAUD_DIV     = 434,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter logic [31:0] TX_DATA_ADDR = 32'h1001_0100,
  parameter logic [31:0] STATUS_ADDR  = 32'h1001_0104
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Mem_Write_i,
  input  logic        Mem_Read_i,
  input  logic [31:0] Address_i,
  input  logic [31:0] Write_Data_i,
  output logic [31:0] Read_Data_o,
  output logic        Tx_o
);

  localparam int unsigned BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  localparam logic [BW-1:0] BaudLast  = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] BaudOne   = BW'(1);
  localparam logic [CW-1:0] CountFull = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CountOne  = CW'(1);
  localparam logic [PW-1:0] PtrOne    = PW'(1);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_e          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic [7:0]      fifo_mem [FIFO_DEPTH];

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic tx_sel, st_sel;
  logic push_req, push, pop;
  logic ovf_clear;
  logic fifo_empty, fifo_full;
  logic baud_tc;
  logic [7:0] fifo_head;

  assign tx_sel     = (Address_i == TX_DATA_ADDR);
  assign st_sel     = (Address_i == STATUS_ADDR);
  assign push_req   = Mem_Write_i & tx_sel;
  assign ovf_clear  = Mem_Write_i & st_sel & Write_Data_i[2];
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CountFull);
  assign baud_tc    = (baud_q == BaudLast);
  assign fifo_head  = fifo_mem[rd_ptr_q];

  // A full FIFO still accepts a store when the FSM pops in the same cycle.
  assign push = push_req & (~fifo_full | pop);

  // Only the low byte and bit 2 of the store data carry meaning.
  logic unused_wdata;
  assign unused_wdata = ^{Write_Data_i[31:8]};

  // ---------------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    pop       = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Pop decision uses the registered count, so a byte stored into an empty
        // FIFO is only seen one cycle later.
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_d   = fifo_head;
          bit_idx_d = 3'd0;
          baud_d    = '0;
          state_d   = StStart;
        end
      end

      StStart: begin
        baud_d = baud_tc ? '0 : baud_q + BaudOne;
        if (baud_tc) begin
          state_d = StData;
        end
      end

      StData: begin
        baud_d = baud_tc ? '0 : baud_q + BaudOne;
        if (baud_tc) begin
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = StStop;
          end
        end
      end

      StStop: begin
        baud_d = baud_tc ? '0 : baud_q + BaudOne;
        if (baud_tc) begin
          if (!fifo_empty) begin
            // Chain straight into the next start bit with no idle gap.
            pop       = 1'b1;
            shift_d   = fifo_head;
            bit_idx_d = 3'd0;
            state_d   = StStart;
          end else begin
            state_d = StIdle;
          end
        end
      end

      default: begin
        state_d = StIdle;
        baud_d  = '0;
      end
    endcase
  end

  // Line level is registered from the next state so Tx_o is glitch-free and
  // changes exactly on the edge that enters each bit period.
  always_comb begin
    tx_d = 1'b1;
    if (state_d == StStart) begin
      tx_d = 1'b0;
    end else if (state_d == StData) begin
      tx_d = shift_d[0];
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO bookkeeping and sticky overflow
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PtrOne : rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    unique case ({push, pop})
      2'b10:   count_d = count_q + CountOne;
      2'b01:   count_d = count_q - CountOne;
      default: count_d = count_q;
    endcase

    if (push_req && !push) begin
      overflow_d = 1'b1;
    end else if (ovf_clear) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      baud_q     <= '0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'h00;
      tx_q       <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= Write_Data_i[7:0];
    end
  end

  assign Tx_o = tx_q;

  // ---------------------------------------------------------------------------
  // Status readback
  // ---------------------------------------------------------------------------
  always_comb begin
    Read_Data_o = '0;
    if (Mem_Read_i && st_sel) begin
      Read_Data_o[0]      = ~fifo_empty | (state_q != StIdle);
      Read_Data_o[1]      = fifo_full;
      Read_Data_o[2]      = overflow_q;
      Read_Data_o[3]      = fifo_empty;
      Read_Data_o[8 +: 5] = 5'(count_q);
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio (BAUD_DIV=4, FIFO_DEPTH=8).
// A queue-based model predicts the serial line and the status word; a compare
// process checks both on every falling edge, and directed sections pin literal
// values for reset, a single frame, back-to-back frames and overflow.
module tb_uart_tx_mmio;

  localparam int unsigned B   = 4;
  localparam int unsigned D   = 8;
  localparam logic [31:0] TXA = 32'h1001_0100;
  localparam logic [31:0] STA = 32'h1001_0104;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        mw    = 1'b0;
  logic        mr    = 1'b0;
  logic [31:0] addr  = '0;
  logic [31:0] wd    = '0;
  logic [31:0] rd;
  logic        tx;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_tx_mmio #(
    .BAUD_DIV    (B),
    .FIFO_DEPTH  (D),
    .TX_DATA_ADDR(TXA),
    .STATUS_ADDR (STA)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .Mem_Write_i (mw),
    .Mem_Read_i  (mr),
    .Address_i   (addr),
    .Write_Data_i(wd),
    .Read_Data_o (rd),
    .Tx_o        (tx)
  );

  // ---------------------------------------------------------------------------
  // Behavioural model: pending bytes, current frame and position in it.
  // ---------------------------------------------------------------------------
  logic [7:0] mq[$];
  logic [9:0] mframe = 10'h3ff;
  int         mpos   = -1;     // cycle index within current frame, -1 when idle
  bit         movf   = 1'b0;

  function automatic logic m_line();
    if (mpos < 0) return 1'b1;
    return mframe[mpos / B];
  endfunction

  function automatic logic [31:0] m_status();
    logic [31:0] s;
    int n;
    s = '0;
    n = mq.size();
    s[0] = (n != 0) || (mpos >= 0);
    s[1] = (n == D);
    s[2] = movf;
    s[3] = (n == 0);
    s[12:8] = 5'(n);
    return s;
  endfunction

  task automatic model_step();
    int sz;
    bit pop;
    logic [7:0] b;
    sz  = mq.size();
    pop = (sz > 0) && (mpos < 0 || mpos == 10 * B - 1);
    if (mpos >= 0) begin
      mpos++;
      if (mpos == 10 * B) mpos = -1;
    end
    if (pop) begin
      b      = mq.pop_front();
      mframe = {1'b1, b, 1'b0};
      mpos   = 0;
    end
    if (mw && addr == TXA) begin
      if (sz < D || pop) mq.push_back(wd[7:0]);
      else movf = 1'b1;
    end
    if (mw && addr == STA && wd[2]) movf = 1'b0;
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        mq.delete();
        mpos = -1;
        movf = 1'b0;
      end else begin
        model_step();
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        chk("tx_line", 32'(tx), 32'(m_line()));
        chk("read_data", rd, (mr && addr == STA) ? m_status() : 32'h0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all start and end at posedge + 1)
  // ---------------------------------------------------------------------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    mw = 1'b1; addr = a; wd = d;
    cyc();
    mw = 1'b0; addr = '0; wd = '0;
  endtask

  task automatic read_status(input string name, input logic [31:0] exp);
    mr = 1'b1; addr = STA;
    #2;
    chk(name, rd, exp);
    cyc();
    mr = 1'b0; addr = '0;
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while ((mq.size() != 0 || mpos >= 0) && n < bound) begin
      cyc();
      n++;
    end
    if (n >= bound) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: still busy after %0d cycles, required idle", bound);
    end
  endtask

  // Async reset pulse between clock edges; Tx_o must go high at once.
  task automatic pulse_reset(input string name, input bit check_status);
    #2 reset = 1'b0;
    #1 chk(name, 32'(tx), 32'h1);
    if (check_status) begin
      mr = 1'b1; addr = STA;
      #1 chk("reset_status", rd, 32'h0000_0008);
      mr = 1'b0; addr = '0;
      #2 reset = 1'b1;
    end else begin
      #3 reset = 1'b1;
    end
    cyc();
  endtask

  function automatic logic [31:0] bogus();
    case ($urandom_range(0, 3))
      0:       return 32'h1001_0108;
      1:       return 32'h1001_0101;
      2:       return 32'h1001_0105;
      default: return $urandom;
    endcase
  endfunction

  logic [9:0] a5_bits = 10'b11_0100_1010;
  logic       exp_bit;
  int         n_wait;
  int         r;

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    cyc();

    // Reset mid-frame: store, then reset during the start bit.
    store(TXA, 32'h5A);
    repeat (2) cyc();
    chk("pre_reset_start_bit", 32'(tx), 32'h0);
    pulse_reset("reset_tx_immediate", 1'b1);
    read_status("idle_status", 32'h0000_0008);

    // Single byte A5: start bit two cycles after the store.
    store(TXA, 32'hFFFF_FFA5);
    cyc();
    for (int k = 0; k < 10 * B; k++) begin
      if (k == 20) begin mr = 1'b1; addr = STA; end
      @(negedge clk);
      chk("a5_line", 32'(tx), 32'(a5_bits[k / B]));
      if (k == 20) chk("a5_busy", rd & 32'h1, 32'h1);
      cyc();
      mr = 1'b0; addr = '0;
    end
    read_status("a5_done", 32'h0000_0008);

    // Back-to-back 00 then FF: 80 cycles, no gap.
    store(TXA, 32'h00);
    store(TXA, 32'hFF);
    for (int k = 0; k < 20 * B; k++) begin
      @(negedge clk);
      exp_bit = (k < 36) ? 1'b0 : (k < 40) ? 1'b1 : (k < 44) ? 1'b0 : 1'b1;
      chk("b2b_line", 32'(tx), 32'(exp_bit));
      cyc();
    end
    read_status("b2b_done", 32'h0000_0008);

    // Overflow: ten stores, one popped early, tenth dropped.
    for (int i = 0; i < 10; i++) store(TXA, 32'h10 + i);
    read_status("ovf_status", 32'h0000_0807);
    store(STA, 32'h4);
    read_status("ovf_cleared", 32'h0000_0803);

    // Push exactly when the FSM pops from a full FIFO.
    n_wait = 0;
    while (!(mpos == 10 * B - 1 && mq.size() == D) && n_wait < 200) begin
      cyc();
      n_wait++;
    end
    if (n_wait >= 200) begin
      total++;
      bad++;
      $display("FAIL pop_wait_timeout: full-FIFO pop point not reached, required within 200 cycles");
    end
    store(TXA, 32'hC3);
    read_status("push_pop_full", 32'h0000_0803);
    wait_idle(9 * 10 * B + 100);
    read_status("drained", 32'h0000_0008);

    // Decode isolation.
    store(32'h1001_0108, 32'hAA);
    store(32'h1001_0101, 32'h55);
    read_status("decode_isolation", 32'h0000_0008);
    mr = 1'b1; addr = TXA;
    #2 chk("read_txdata", rd, 32'h0);
    cyc();
    mr = 1'b0; addr = STA;
    #2 chk("no_read_enable", rd, 32'h0);
    cyc();
    addr = '0;

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      if (i == 1700) begin
        pulse_reset("random_reset_tx", 1'b0);
      end else if (r < 12) begin
        store(TXA, $urandom);
      end else if (r < 16) begin
        store(STA, $urandom);
      end else if (r < 20) begin
        store(bogus(), $urandom);
      end else if (r < 32) begin
        mr = 1'b1;
        case ($urandom_range(0, 2))
          0:       addr = STA;
          1:       addr = TXA;
          default: addr = bogus();
        endcase
        cyc();
        mr = 1'b0; addr = '0;
      end else begin
        cyc();
      end
    end
    wait_idle(9 * 10 * B + 100);
    store(STA, 32'h4);
    read_status("final_idle", 32'h0000_0008);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
